// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Constants shared by the MIPS pipeline stages (fetch, decode,
//               control). NOP and HALT encodings must agree across stages.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int          NB_DATA    = 32;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam logic [31:0] INSTR_HALT = 32'hFFFF_FFFF;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : MEM_DEPTH x NB_DATA instruction store. One synchronous write
//               port (debug loader) and one asynchronous read port (fetch).
//               No reset: contents survive a core reset.
// Ports       : clk                  - clock
//               i_we / i_waddr / i_wdata - write port (rising edge)
//               i_raddr              - read word index
//               o_rdata              - combinational read data
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter  int NB_DATA     = mips_pkg::NB_DATA,
    parameter  int MEM_DEPTH   = 256,
    localparam int NB_MEM_ADDR = $clog2(MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [NB_MEM_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0]     i_wdata,
    input  logic [NB_MEM_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0]     o_rdata
);

    logic [NB_DATA-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A read of the word being written this cycle returns the old contents.
    assign o_rdata = r_mem[i_raddr];

endmodule : instruction_memory
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Pipeline stage 1 of the 5-stage MIPS core. Holds the PC,
//               the instruction memory and the IF/ID register. Applies, in
//               priority order: redirect, halt drain, stall, flush, fetch.
// Ports       : clk, i_rst_n         - clock, async active-low reset
//               i_enable             - debug run gate (0 freezes all state)
//               i_stall / i_flush    - hazard unit requests
//               i_pc_src / i_target  - branch/jump redirect
//               i_imem_*             - debug instruction-memory write port
//               o_instruction        - IF/ID instruction
//               o_pcounter4          - IF/ID PC+4
//               o_pc                 - current PC
//               o_halt               - HALT fetched, pipeline draining
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter  int NB_DATA     = mips_pkg::NB_DATA,
    parameter  int MEM_DEPTH   = 256,
    localparam int NB_MEM_ADDR = $clog2(MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_pc_src,
    input  logic [NB_DATA-1:0]     i_target,
    input  logic                   i_imem_we,
    input  logic [NB_MEM_ADDR-1:0] i_imem_waddr,
    input  logic [NB_DATA-1:0]     i_imem_wdata,
    output logic [NB_DATA-1:0]     o_instruction,
    output logic [NB_DATA-1:0]     o_pcounter4,
    output logic [NB_DATA-1:0]     o_pc,
    output logic                   o_halt
);

    localparam logic [NB_DATA-1:0] c_nop  = NB_DATA'(mips_pkg::INSTR_NOP);
    localparam logic [NB_DATA-1:0] c_halt = NB_DATA'(mips_pkg::INSTR_HALT);
    localparam logic [NB_DATA-1:0] c_four = NB_DATA'(4);

    logic [NB_DATA-1:0] r_pc;
    logic [NB_DATA-1:0] r_instruction;
    logic [NB_DATA-1:0] r_pcounter4;
    logic               r_halted;

    logic [NB_DATA-1:0] w_word;
    logic [NB_DATA-1:0] w_pc_plus4;
    logic [NB_DATA-1:0] w_target_aligned;
    logic               w_unused_target_bits;

    // PC bits above the word index are ignored: fetch wraps modulo MEM_DEPTH*4.
    instruction_memory #(
        .NB_DATA   (NB_DATA),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_imem (
        .clk     (clk),
        .i_we    (i_imem_we),
        .i_waddr (i_imem_waddr),
        .i_wdata (i_imem_wdata),
        .i_raddr (r_pc[NB_MEM_ADDR+1:2]),
        .o_rdata (w_word)
    );

    assign w_pc_plus4           = r_pc + c_four;
    // Misaligned target bits are dropped rather than trapped.
    assign w_target_aligned     = {i_target[NB_DATA-1:2], 2'b00};
    assign w_unused_target_bits = &i_target[1:0];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= '0;
            r_instruction <= c_nop;
            r_pcounter4   <= '0;
            r_halted      <= 1'b0;
        end else if (i_enable) begin
            if (i_pc_src) begin
                // Redirect wins over stall and halt: a HALT fetched down a
                // mispredicted path must be cancelled.
                r_pc          <= w_target_aligned;
                r_instruction <= c_nop;
                r_pcounter4   <= '0;
                r_halted      <= 1'b0;
            end else if (r_halted) begin
                r_instruction <= c_nop;
                r_pcounter4   <= '0;
            end else if (i_stall) begin
                r_pc          <= r_pc;
            end else if (i_flush) begin
                r_instruction <= c_nop;
                r_pcounter4   <= '0;
                r_pc          <= w_pc_plus4;
            end else begin
                r_instruction <= w_word;
                r_pcounter4   <= w_pc_plus4;
                if (w_word == c_halt) begin
                    r_halted <= 1'b1;
                end else begin
                    r_pc     <= w_pc_plus4;
                end
            end
        end
    end

    assign o_instruction = r_instruction;
    assign o_pcounter4   = r_pcounter4;
    assign o_pc          = r_pc;
    assign o_halt        = r_halted;

endmodule : instruction_fetch
`default_nettype wire
